// File: rtl/call_stack_unit.sv
// Return-address stack: circular buffer with full/empty status, sticky errors, tail-call replace and flush.
// Define CALL_STACK_WRAP_EN to overwrite the oldest entry on a full push instead of dropping it.
module call_stack_unit #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              ret_valid,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              ovf_err,
    output logic              unf_err,
    output logic              wrapped
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic              ret_valid_q, ret_valid_d;
    logic              ovf_err_q, ovf_err_d;
    logic              unf_err_q, unf_err_d;
    logic              wrapped_q, wrapped_d;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [PTR_W-1:0]  ptr_dec;
    logic              is_empty;
    logic              is_full;

    assign ptr_dec  = wr_ptr_q - 1'b1;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    // Top is read combinationally so the control unit can see it without a cycle of latency.
    assign top       = is_empty ? '0 : mem[ptr_dec];
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign ret_addr  = ret_addr_q;
    assign ret_valid = ret_valid_q;
    assign ovf_err   = ovf_err_q;
    assign unf_err   = unf_err_q;
    assign wrapped   = wrapped_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = 1'b0;
        ovf_err_d   = ovf_err_q;
        unf_err_d   = unf_err_q;
        wrapped_d   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;

        if (flush) begin
            wr_ptr_d  = '0;
            count_d   = '0;
            ovf_err_d = 1'b0;
            unf_err_d = 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!is_full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end else begin
`ifdef CALL_STACK_WRAP_EN
                        mem_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                        wrapped_d = 1'b1;
`else
                        ovf_err_d = 1'b1;
`endif
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        ret_addr_d  = top;
                        ret_valid_d = 1'b1;
                        wr_ptr_d    = ptr_dec;
                        count_d     = count_q - 1'b1;
                    end else begin
                        unf_err_d = 1'b1;
                    end
                end
                2'b11: begin
                    ret_valid_d = 1'b1;
                    if (!is_empty) begin
                        // Tail call: return the old top and overwrite it in place.
                        ret_addr_d = top;
                        mem_we     = 1'b1;
                        mem_waddr  = ptr_dec;
                    end else begin
                        ret_addr_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
            ovf_err_q   <= 1'b0;
            unf_err_q   <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
            ovf_err_q   <= ovf_err_d;
            unf_err_q   <= unf_err_d;
            wrapped_q   <= wrapped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= push_data;
        end
    end

endmodule

// File: tb/tb_call_stack_unit.sv
// Directed bench for call_stack_unit (DEPTH=4, ADDR_W=16); full-push expectations follow CALL_STACK_WRAP_EN.
module tb_call_stack_unit;

    logic        clk = 1'b0;
    logic        rst, push, pop, flush;
    logic [15:0] push_data;
    logic [15:0] ret_addr, top;
    logic        ret_valid, empty, full, ovf_err, unf_err, wrapped;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef CALL_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    call_stack_unit #(.ADDR_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
        .push_data(push_data), .ret_addr(ret_addr), .ret_valid(ret_valid),
        .top(top), .count(count), .empty(empty), .full(full),
        .ovf_err(ovf_err), .unf_err(unf_err), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push, pop, flush;
        logic [15:0] data;
        logic        rv;
        logic [15:0] ra;
        logic [15:0] tp;
        logic [2:0]  cnt;
        logic        ovf, unf;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic f, input logic [15:0] d);
        push = p; pop = q; flush = f; push_data = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic rv, input logic [15:0] ra,
                             input logic [15:0] tp, input logic [2:0] cnt,
                             input logic ovf, input logic unf, input logic wr);
        chk({tag, ".ret_valid"}, 32'(ret_valid), 32'(rv));
        if (rv) chk({tag, ".ret_addr"}, 32'(ret_addr), 32'(ra));
        chk({tag, ".top"}, 32'(top), 32'(tp));
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".empty"}, 32'(empty), 32'(cnt == 3'd0));
        chk({tag, ".full"}, 32'(full), 32'(cnt == 3'd4));
        chk({tag, ".ovf_err"}, 32'(ovf_err), 32'(ovf));
        chk({tag, ".unf_err"}, 32'(unf_err), 32'(unf));
        chk({tag, ".wrapped"}, 32'(wrapped), 32'(wr));
        $display("%s: push=%0b pop=%0b flush=%0b rv=%0b ra=%h top=%h cnt=%0d ovf=%0b unf=%0b wr=%0b",
                 tag, push, pop, flush, ret_valid, ret_addr, top, count, ovf_err, unf_err, wrapped);
    endtask

    initial begin
        //             push pop flush data      rv  ra        top       cnt  ovf unf
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 1'b0, 16'h0000, 16'h0010, 3'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0020, 1'b0, 16'h0000, 16'h0020, 3'd2, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0030, 1'b0, 16'h0000, 16'h0030, 3'd3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0030, 16'h0020, 3'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0020, 16'h0010, 3'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 16'h0000, 16'h0100, 3'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0200, 1'b1, 16'h0100, 16'h0200, 3'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0200, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0300, 1'b1, 16'h0300, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 16'h0000, 16'h0005, 3'd1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 16'h0077, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};

        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("reset.ret_addr", 32'(ret_addr), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].data);
            chk_state($sformatf("vec%0d", i), vecs[i].rv, vecs[i].ra, vecs[i].tp,
                      vecs[i].cnt, vecs[i].ovf, vecs[i].unf, 1'b0);
        end
        // Failed pop must leave the last returned address in place.
        chk("hold.ret_addr", 32'(ret_addr), 32'h0300);

        // Fill past capacity; the fifth push either drops (ovf) or overwrites the oldest (wrapped).
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'(i));
            chk_state($sformatf("fill%0d", i), 1'b0, 16'h0,
                      (i == 5) ? (WRAP ? 16'h0005 : 16'h0004) : 16'(i),
                      (i >= 4) ? 3'd4 : 3'(i),
                      (!WRAP && i == 5), 1'b0, (WRAP && i == 5));
        end

        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_ra, exp_tp;
            exp_ra = WRAP ? 16'(5 - i) : 16'(4 - i);
            exp_tp = (i == 3) ? 16'h0 : exp_ra - 16'h1;
            step(1'b0, 1'b1, 1'b0, 16'h0);
            chk_state($sformatf("drain%0d", i), 1'b1, exp_ra, exp_tp, 3'(3 - i),
                      !WRAP, 1'b0, 1'b0);
        end

        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk_state("idle", 1'b0, 16'h0, 16'h0, 3'd0, !WRAP, 1'b0, 1'b0);

        // Reset outranks a concurrent push and clears sticky errors.
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 16'h00AA);
        rst = 1'b0;
        chk_state("rst_push", 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_push.ret_addr", 32'(ret_addr), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
